// File: rtl/decodificador_instrucao_pkg.sv
// Shared opcode, addressing-mode and run-state encodings for the instruction decoder.
// Imported by the decoder, the control unit and the assembler tests.
package decodificador_instrucao_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_STA = 4'h1;
    localparam logic [3:0] OP_LDA = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_OR  = 4'h6;
    localparam logic [3:0] OP_NOT = 4'h7;
    localparam logic [3:0] OP_J   = 4'h8;
    localparam logic [3:0] OP_JN  = 4'h9;
    localparam logic [3:0] OP_JZ  = 4'hA;
    localparam logic [3:0] OP_IN  = 4'hB;
    localparam logic [3:0] OP_OUT = 4'hC;
    localparam logic [3:0] OP_SHR = 4'hD;
    localparam logic [3:0] OP_SHL = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [1:0] MODE_DIR = 2'b00;
    localparam logic [1:0] MODE_IND = 2'b01;
    localparam logic [1:0] MODE_IM  = 2'b10;
    localparam logic [1:0] MODE_SOP = 2'b11;

    typedef enum logic [1:0] {
        ST_HALT = 2'b00,
        ST_RUN  = 2'b01,
        ST_TRAP = 2'b10
    } state_t;

endpackage

// File: rtl/decodificador_opcode.sv
// One-hot opcode/mode decode and legality check of an instruction word.
// Latency: purely combinational. Backpressure: none, no handshake.
module decodificador_opcode
    import decodificador_instrucao_pkg::*;
(
    input  logic [3:0]  opcode,
    input  logic [1:0]  mode,
    output logic [15:0] opHot,
    output logic [3:0]  modeHot,
    output logic        illegal
);

    logic sopOnly;

    always_comb begin
        opHot           = '0;
        opHot[opcode]   = 1'b1;
        modeHot         = '0;
        modeHot[mode]   = 1'b1;
    end

    // Operand-less instructions must use SOP; every other instruction must not.
    always_comb begin
        sopOnly = (opcode == OP_NOP) || (opcode == OP_NOT) || (opcode == OP_SHR) ||
                  (opcode == OP_SHL) || (opcode == OP_HLT);
        illegal = sopOnly != (mode == MODE_SOP);
    end

endmodule

// File: rtl/decodificador_instrucao.sv
// Instruction register, N/Z flags and RUN/HALT/TRAP sequencing ahead of the control unit.
// Latency: strobes valid the cycle after writeRI; run drops the cycle after the T3 edge.
// Backpressure: run is the processor clock-enable; RI and flag writes are ignored while stopped.
module decodificador_instrucao
    import decodificador_instrucao_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int OPC_MSB = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] rdm,
    input  logic             writeRI,
    input  logic [WIDTH-1:0] ula_res,
    input  logic             writeN,
    input  logic             writeZ,
    input  logic             T3,
    input  logic             start,
    output logic             sNOP,
    output logic             sSTA,
    output logic             sLDA,
    output logic             sADD,
    output logic             sSUB,
    output logic             sAND,
    output logic             sOR,
    output logic             sNOT,
    output logic             sJ,
    output logic             sJN,
    output logic             sJZ,
    output logic             sIN,
    output logic             sOUT,
    output logic             sSHR,
    output logic             sSHL,
    output logic             sHLT,
    output logic             sDIR,
    output logic             sIND,
    output logic             sIM,
    output logic             sSOP,
    output logic             sN,
    output logic             sZ,
    output logic             run,
    output logic             illegal,
    output logic [WIDTH-1:0] ri
);

    logic [WIDTH-1:0] riReg;
    logic             flagN;
    logic             flagZ;
    state_t           state;
    state_t           nextState;
    logic [15:0]      opHot;
    logic [3:0]       modeHot;
    logic             instIllegal;

    decodificador_opcode uDecode (
        .opcode  (riReg[OPC_MSB -: 4]),
        .mode    (riReg[1:0]),
        .opHot   (opHot),
        .modeHot (modeHot),
        .illegal (instIllegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_HALT;
            riReg <= '0;
            flagN <= 1'b0;
            flagZ <= 1'b0;
        end else begin
            state <= nextState;
            if (run && writeRI) riReg <= rdm;
            if (run && writeN)  flagN <= ula_res[WIDTH-1];
            if (run && writeZ)  flagZ <= (ula_res == '0);
        end
    end

    // Decision uses the RI value present before this edge, even if writeRI reloads it.
    always_comb begin
        nextState = state;
        case (state)
            ST_HALT: if (start) nextState = ST_RUN;
            ST_RUN: begin
                if (T3) begin
                    if (instIllegal)      nextState = ST_TRAP;
                    else if (opHot[OP_HLT]) nextState = ST_HALT;
                end
            end
            ST_TRAP: if (start) nextState = ST_RUN;
            default: nextState = ST_HALT;
        endcase
    end

    assign run     = (state == ST_RUN);
    assign illegal = (state == ST_TRAP);
    assign ri      = riReg;
    assign sN      = flagN;
    assign sZ      = flagZ;

    assign sNOP = opHot[OP_NOP];
    assign sSTA = opHot[OP_STA];
    assign sLDA = opHot[OP_LDA];
    assign sADD = opHot[OP_ADD];
    assign sSUB = opHot[OP_SUB];
    assign sAND = opHot[OP_AND];
    assign sOR  = opHot[OP_OR];
    assign sNOT = opHot[OP_NOT];
    assign sJ   = opHot[OP_J];
    assign sJN  = opHot[OP_JN];
    assign sJZ  = opHot[OP_JZ];
    assign sIN  = opHot[OP_IN];
    assign sOUT = opHot[OP_OUT];
    assign sSHR = opHot[OP_SHR];
    assign sSHL = opHot[OP_SHL];
    assign sHLT = opHot[OP_HLT];

    assign sDIR = modeHot[MODE_DIR];
    assign sIND = modeHot[MODE_IND];
    assign sIM  = modeHot[MODE_IM];
    assign sSOP = modeHot[MODE_SOP];

endmodule

// File: tb/tb_decodificador_instrucao.sv
// Directed bench for decodificador_instrucao: decode sweep, flags, halt/trap sequencing, async reset.
module tb_decodificador_instrucao;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rdm;
    logic       writeRI;
    logic [7:0] ula_res;
    logic       writeN, writeZ, T3, start;
    logic sNOP, sSTA, sLDA, sADD, sSUB, sAND, sOR, sNOT;
    logic sJ, sJN, sJZ, sIN, sOUT, sSHR, sSHL, sHLT;
    logic sDIR, sIND, sIM, sSOP, sN, sZ, run, illegal;
    logic [7:0] ri;

    logic [15:0] opVec;
    logic [3:0]  modeVec;
    int total = 0;
    int bad   = 0;

    assign opVec   = {sHLT, sSHL, sSHR, sOUT, sIN, sJZ, sJN, sJ,
                      sNOT, sOR, sAND, sSUB, sADD, sLDA, sSTA, sNOP};
    assign modeVec = {sSOP, sIM, sIND, sDIR};

    always #5 clk = ~clk;

    decodificador_instrucao #(.WIDTH(8), .OPC_MSB(7)) dut (
        .clk(clk), .rst_n(rst_n), .rdm(rdm), .writeRI(writeRI), .ula_res(ula_res),
        .writeN(writeN), .writeZ(writeZ), .T3(T3), .start(start),
        .sNOP(sNOP), .sSTA(sSTA), .sLDA(sLDA), .sADD(sADD), .sSUB(sSUB), .sAND(sAND),
        .sOR(sOR), .sNOT(sNOT), .sJ(sJ), .sJN(sJN), .sJZ(sJZ), .sIN(sIN), .sOUT(sOUT),
        .sSHR(sSHR), .sSHL(sSHL), .sHLT(sHLT), .sDIR(sDIR), .sIND(sIND), .sIM(sIM),
        .sSOP(sSOP), .sN(sN), .sZ(sZ), .run(run), .illegal(illegal), .ri(ri)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic loadRI(input logic [7:0] v);
        rdm = v; writeRI = 1'b1;
        tick();
        writeRI = 1'b0;
    endtask

    task automatic pulseT3();
        T3 = 1'b1;
        tick();
        T3 = 1'b0;
    endtask

    task automatic pulseStart();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; rdm = '0; writeRI = 1'b0; ula_res = '0;
        writeN = 1'b0; writeZ = 1'b0; T3 = 1'b0; start = 1'b0;
        #3;
        check("rst_run", {31'd0, run}, 32'd0);
        check("rst_illegal", {31'd0, illegal}, 32'd0);
        check("rst_ri", {24'd0, ri}, 32'h00);
        check("rst_flags", {30'd0, sN, sZ}, 32'd0);
        check("rst_op", {16'd0, opVec}, 32'h0001);
        check("rst_mode", {28'd0, modeVec}, 32'h1);
        tick();
        #2 rst_n = 1'b1;
        tick();
        check("halt_after_rst", {31'd0, run}, 32'd0);

        // Loads and flag writes are ignored while halted
        rdm = 8'h32; writeRI = 1'b1; ula_res = 8'h80; writeN = 1'b1;
        tick();
        writeRI = 1'b0; writeN = 1'b0;
        check("halt_ri_ignored", {24'd0, ri}, 32'h00);
        check("halt_flag_ignored", {31'd0, sN}, 32'd0);

        pulseStart();
        check("start_run", {31'd0, run}, 32'd1);

        loadRI(8'h32);
        check("add_im_op", {16'd0, opVec}, 32'h0008);
        check("add_im_mode", {28'd0, modeVec}, 32'h4);

        for (int op = 0; op < 16; op++) begin
            for (int md = 0; md < 4; md++) begin
                loadRI(8'((op << 4) | (((op + md) & 3) << 2) | md));
                check($sformatf("sweep_op_%0h_%0d", op, md), {16'd0, opVec}, 32'(1 << op));
                check($sformatf("sweep_mode_%0h_%0d", op, md), {28'd0, modeVec}, 32'(1 << md));
            end
        end
        check("sweep_still_run", {31'd0, run}, 32'd1);

        ula_res = 8'h80; writeN = 1'b1; writeZ = 1'b1;
        tick();
        writeN = 1'b0; writeZ = 1'b0;
        check("flag_n_set", {31'd0, sN}, 32'd1);
        check("flag_z_clr", {31'd0, sZ}, 32'd0);
        ula_res = 8'h00; writeZ = 1'b1;
        tick();
        writeZ = 1'b0;
        check("flag_n_hold", {31'd0, sN}, 32'd1);
        check("flag_z_set", {31'd0, sZ}, 32'd1);
        loadRI(8'h00);
        check("flag_hold_on_ri", {30'd0, sN, sZ}, 32'd3);

        pulseStart();
        check("start_in_run", {31'd0, run}, 32'd1);

        loadRI(8'h32);
        pulseT3();
        check("legal_t3_run", {31'd0, run}, 32'd1);

        loadRI(8'hF3);
        pulseT3();
        check("hlt_run", {31'd0, run}, 32'd0);
        check("hlt_not_illegal", {31'd0, illegal}, 32'd0);
        loadRI(8'h20);
        check("hlt_ri_kept", {24'd0, ri}, 32'hF3);
        ula_res = 8'h01; writeZ = 1'b1;
        tick();
        writeZ = 1'b0;
        check("hlt_z_kept", {31'd0, sZ}, 32'd1);
        pulseStart();
        check("hlt_restart", {31'd0, run}, 32'd1);

        loadRI(8'h70);
        pulseT3();
        check("trap_illegal", {31'd0, illegal}, 32'd1);
        check("trap_run", {31'd0, run}, 32'd0);
        check("trap_ri_kept", {24'd0, ri}, 32'h70);
        pulseStart();
        check("trap_clear", {31'd0, illegal}, 32'd0);
        check("trap_restart", {31'd0, run}, 32'd1);
        loadRI(8'h23);
        pulseT3();
        check("trap_lda_sop", {31'd0, illegal}, 32'd1);
        pulseStart();

        // Same-edge load and T3: decision on old RI, load still happens
        loadRI(8'h32);
        rdm = 8'hF3; writeRI = 1'b1; T3 = 1'b1;
        tick();
        writeRI = 1'b0; T3 = 1'b0;
        check("same_edge_old_legal", {31'd0, run}, 32'd1);
        check("same_edge_load", {24'd0, ri}, 32'hF3);
        rdm = 8'h32; writeRI = 1'b1; T3 = 1'b1;
        tick();
        writeRI = 1'b0; T3 = 1'b0;
        check("same_edge_old_hlt", {31'd0, run}, 32'd0);
        check("same_edge_load_hlt", {24'd0, ri}, 32'h32);
        pulseStart();

        loadRI(8'h51);
        ula_res = 8'h80; writeN = 1'b1;
        tick();
        writeN = 1'b0;
        check("pre_arst_n", {31'd0, sN}, 32'd1);
        check("pre_arst_op", {16'd0, opVec}, 32'h0020);
        #2 rst_n = 1'b0;
        #1;
        check("arst_run", {31'd0, run}, 32'd0);
        check("arst_ri", {24'd0, ri}, 32'h00);
        check("arst_n", {31'd0, sN}, 32'd0);
        check("arst_op", {16'd0, opVec}, 32'h0001);
        check("arst_mode", {28'd0, modeVec}, 32'h1);
        tick();
        rst_n = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
